// File: rtl/seg7_pkg.sv
// Shared constants, state encoding and glyph table for the 7-segment scan controller.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK_AL = 7'h7F;

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  // Ceiling log2, never below 1 so counters always have at least one bit.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) begin
        res = i + 1;
      end
    end
    return (res < 1) ? 1 : res;
  endfunction

  // Active-low hex glyphs, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_glyph_al(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_BLANK_AL;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_dec.sv
// Nibble-to-segment decoders: full hex glyph set, or decimal-only with A-F blank.
module hex2digit_hex
  import seg7_pkg::*;
#(
  parameter int INVERT = 1
) (
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = (INVERT != 0) ? hex_glyph_al(nib_i) : ~hex_glyph_al(nib_i);

endmodule

module hex2digit_dec
  import seg7_pkg::*;
#(
  parameter int INVERT = 1
) (
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  logic [6:0] glyph_al_s;

  assign glyph_al_s = (nib_i > 4'd9) ? SEG_BLANK_AL : hex_glyph_al(nib_i);
  assign seg_o      = (INVERT != 0) ? glyph_al_s : ~glyph_al_s;

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed N-digit 7-segment scan controller with guard blanking, frame-coherent
// load handshake and optional leading-zero suppression. rst_n is expected release-synchronised upstream.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SLOT_CYC   = 50000,
  parameter int GUARD_CYC  = 500,
  parameter int DEC_MODE   = 0,
  parameter int INVERT     = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic                    lz_en_i,
  output logic [6:0]              seg_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_o
);

  localparam int IDX_W = clog2(NUM_DIGITS);
  localparam int CNT_W = clog2(SLOT_CYC);
  localparam logic [6:0]            SEG_BLANK = (INVERT != 0) ? SEG_BLANK_AL : 7'h00;
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(SLOT_CYC - 1);
  localparam logic [CNT_W-1:0]      CNT_GUARD = CNT_W'(GUARD_CYC);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE    = NUM_DIGITS'(1);

  logic [CNT_W-1:0]        slot_cnt_q, slot_cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  scan_state_e             state_q, state_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
  logic                    pend_vld_q, pend_vld_d;
  logic                    lz_q, lz_d;
  logic                    lz_pend_q, lz_pend_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_q, frame_d;

  logic                    cnt_wrap_s;
  logic                    frame_wrap_s;
  logic                    xfer_s;
  logic                    commit_s;
  logic                    zero_run_s;
  logic [NUM_DIGITS-1:0]   lz_mask_s;
  logic [3:0]              nib_s;
  logic [6:0]              dec_seg_s;

  // A digit is a leading zero when it and every digit above it are zero; digit 0 never is.
  always_comb begin
    zero_run_s = 1'b1;
    lz_mask_s  = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run_s   = zero_run_s & (shadow_q[4*k +: 4] == 4'h0);
      lz_mask_s[k] = lz_q & zero_run_s;
    end
  end

  // Decoder is fed from the next digit index so its output registers alongside an_o.
  assign nib_s = shadow_q[{idx_d, 2'b00} +: 4];

  generate
    if (DEC_MODE == 0) begin : g_hex
      hex2digit_hex #(.INVERT(INVERT)) u_dec (.nib_i(nib_s), .seg_o(dec_seg_s));
    end else begin : g_dec
      hex2digit_dec #(.INVERT(INVERT)) u_dec (.nib_i(nib_s), .seg_o(dec_seg_s));
    end
  endgenerate

  // Next-state: slot/digit counters, scan FSM, handshake registers and display outputs.
  always_comb begin
    cnt_wrap_s   = (slot_cnt_q == CNT_LAST);
    frame_wrap_s = cnt_wrap_s && (idx_q == IDX_LAST);
    xfer_s       = valid_i && !pend_vld_q;
    commit_s     = frame_wrap_s && pend_vld_q;

    if (cnt_wrap_s) begin
      slot_cnt_d = '0;
    end else begin
      slot_cnt_d = slot_cnt_q + CNT_W'(1);
    end

    if (frame_wrap_s) begin
      idx_d = '0;
    end else if (cnt_wrap_s) begin
      idx_d = idx_q + IDX_W'(1);
    end else begin
      idx_d = idx_q;
    end

    case (state_q)
      ST_GUARD: state_d = (slot_cnt_d == CNT_GUARD) ? ST_DRIVE : ST_GUARD;
      ST_DRIVE: state_d = cnt_wrap_s ? ST_GUARD : ST_DRIVE;
      default:  state_d = ST_GUARD;
    endcase

    // Commit and accept are exclusive: accepting needs an empty pending slot.
    if (commit_s) begin
      shadow_d   = pending_q;
      lz_d       = lz_pend_q;
    end else begin
      shadow_d   = shadow_q;
      lz_d       = lz_q;
    end

    if (xfer_s) begin
      pending_d  = value_i;
      lz_pend_d  = lz_en_i;
      pend_vld_d = 1'b1;
    end else if (commit_s) begin
      pending_d  = pending_q;
      lz_pend_d  = lz_pend_q;
      pend_vld_d = 1'b0;
    end else begin
      pending_d  = pending_q;
      lz_pend_d  = lz_pend_q;
      pend_vld_d = pend_vld_q;
    end

    if (state_d == ST_DRIVE) begin
      an_d  = ~(AN_ONE << idx_d);
      seg_d = lz_mask_s[idx_d] ? SEG_BLANK : dec_seg_s;
    end else begin
      an_d  = '1;
      seg_d = SEG_BLANK;
    end

    frame_d = frame_wrap_s;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_q <= '0;
      idx_q      <= '0;
      state_q    <= ST_GUARD;
      shadow_q   <= '0;
      pending_q  <= '0;
      pend_vld_q <= 1'b0;
      lz_q       <= 1'b0;
      lz_pend_q  <= 1'b0;
      seg_q      <= SEG_BLANK;
      an_q       <= '1;
      frame_q    <= 1'b0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      idx_q      <= idx_d;
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      pending_q  <= pending_d;
      pend_vld_q <= pend_vld_d;
      lz_q       <= lz_d;
      lz_pend_q  <= lz_pend_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      frame_q    <= frame_d;
    end
  end

  assign seg_o   = seg_q;
  assign an_o    = an_q;
  assign frame_o = frame_q;
  assign ready_o = ~pend_vld_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench: a timeline model of the scan display predicts every cycle for a hex and a decimal instance.
module tb_seg7_scan_ctrl;

  localparam int ND    = 4;
  localparam int SLOT  = 8;
  localparam int GUARD = 2;
  localparam int FRAME = ND * SLOT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic        valid;
  logic        lz_en;

  logic        ready_h, ready_d, frame_h, frame_d;
  logic [6:0]  seg_h, seg_d;
  logic [3:0]  an_h, an_d;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.NUM_DIGITS(ND), .SLOT_CYC(SLOT), .GUARD_CYC(GUARD), .DEC_MODE(0), .INVERT(1)) u_hex (
    .clk(clk), .rst_n(rst_n), .value_i(value), .valid_i(valid), .ready_o(ready_h),
    .lz_en_i(lz_en), .seg_o(seg_h), .an_o(an_h), .frame_o(frame_h));

  seg7_scan_ctrl #(.NUM_DIGITS(ND), .SLOT_CYC(SLOT), .GUARD_CYC(GUARD), .DEC_MODE(1), .INVERT(1)) u_dec (
    .clk(clk), .rst_n(rst_n), .value_i(value), .valid_i(valid), .ready_o(ready_d),
    .lz_en_i(lz_en), .seg_o(seg_d), .an_o(an_d), .frame_o(frame_d));

  // Active-high reference glyphs 0-F; the display uses their complement.
  logic [6:0] glyph_ah [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct {
    logic [6:0] seg_h;
    logic [6:0] seg_d;
    logic [3:0] an;
    logic       frame;
    logic       ready;
  } exp_t;

  exp_t exp_q[$];

  int          m_cyc;
  bit          m_pend;
  logic [15:0] m_pend_v, m_disp;
  logic        m_pend_lz, m_lz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_seg(input logic [15:0] v, input logic lz, input int d, input bit dec);
    logic [3:0] nib;
    nib = v[4*d +: 4];
    if (lz && d != 0 && (v >> (4*d)) == 16'h0) return 7'h7F;
    if (dec && nib > 4'd9) return 7'h7F;
    return ~glyph_ah[nib];
  endfunction

  // Reference model: position in the frame follows from elapsed cycles since reset.
  always @(posedge clk) begin
    exp_t e;
    bit   xfer;
    int   pos, d, off;
    if (!rst_n) begin
      m_cyc = 0; m_pend = 0; m_pend_v = 16'h0; m_pend_lz = 1'b0; m_disp = 16'h0; m_lz = 1'b0;
    end else begin
      xfer = valid && !m_pend;
      m_cyc++;
      if (m_cyc % FRAME == 0 && m_pend) begin
        m_disp = m_pend_v; m_lz = m_pend_lz; m_pend = 0;
      end
      if (xfer) begin
        m_pend = 1; m_pend_v = value; m_pend_lz = lz_en;
      end
    end
    pos = m_cyc % FRAME;
    d   = pos / SLOT;
    off = pos % SLOT;
    e.frame = (m_cyc != 0) && (pos == 0);
    e.ready = !m_pend;
    if (off < GUARD) begin
      e.an = 4'hF; e.seg_h = 7'h7F; e.seg_d = 7'h7F;
    end else begin
      e.an    = ~(4'b0001 << d);
      e.seg_h = exp_seg(m_disp, m_lz, d, 1'b0);
      e.seg_d = exp_seg(m_disp, m_lz, d, 1'b1);
    end
    exp_q.push_back(e);
  end

  // Monitor: compare every presented cycle against the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("seg_hex",   32'(seg_h),   32'(e.seg_h));
      check("seg_dec",   32'(seg_d),   32'(e.seg_d));
      check("an_hex",    32'(an_h),    32'(e.an));
      check("an_dec",    32'(an_d),    32'(e.an));
      check("frame_hex", 32'(frame_h), 32'(e.frame));
      check("frame_dec", 32'(frame_d), 32'(e.frame));
      check("ready_hex", 32'(ready_h), 32'(e.ready));
      check("ready_dec", 32'(ready_d), 32'(e.ready));
    end
  end

  task automatic load(input logic [15:0] v, input logic l);
    @(negedge clk); #1;
    valid = 1'b1; value = v; lz_en = l;
    @(negedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic wait_ready(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (ready_h) return;
    end
    n_vec++; n_fail++;
    $display("FAIL wait_ready: ready_o still %b after %0d cycles", ready_h, bound);
  endtask

  logic [15:0] masks [5] = '{16'hFFFF, 16'h00FF, 16'h000F, 16'h0F0F, 16'h0000};

  initial begin
    bit seen;
    rst_n = 1'b0; valid = 1'b0; value = 16'h0; lz_en = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(negedge clk);

    load(16'h12AF, 1'b0);  wait_ready(80); repeat (40) @(negedge clk);
    load(16'h0050, 1'b1);  wait_ready(80); repeat (40) @(negedge clk);
    load(16'h0000, 1'b1);  wait_ready(80); repeat (40) @(negedge clk);
    load(16'h0B00, 1'b1);  wait_ready(80); repeat (40) @(negedge clk);

    // Overlapping request while a load is pending must be dropped.
    wait_ready(80);
    load(16'h3456, 1'b0);
    load(16'hFFFF, 1'b0);
    wait_ready(80); repeat (40) @(negedge clk);

    // Request presented during the frame_o cycle commits one frame later.
    seen = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (frame_h) seen = 1;
    end
    check("frame_seen", 32'(seen), 32'd1);
    #1 valid = 1'b1; value = 16'h9876; lz_en = 1'b0;
    @(negedge clk); #1 valid = 1'b0;
    wait_ready(80); repeat (40) @(negedge clk);

    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      valid = ($urandom_range(0, 3) == 0);
      value = 16'($urandom) & masks[$urandom_range(0, 4)];
      lz_en = 1'($urandom_range(0, 1));
    end
    #1 valid = 1'b0;
    load(16'h4321, 1'b0); wait_ready(80);

    // Asynchronous reset in the middle of slot 2's drive phase.
    seen = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (an_h == 4'b1011) seen = 1;
    end
    check("slot2_seen", 32'(seen), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_an_hex",  32'(an_h),  32'hF);
    check("rst_seg_hex", 32'(seg_h), 32'h7F);
    check("rst_an_dec",  32'(an_d),  32'hF);
    check("rst_seg_dec", 32'(seg_d), 32'h7F);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (70) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
